// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, defaults and baud-divisor helper (rx and tx).
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + (baud / 2)) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Brief    : Two-flop synchroniser for a single asynchronous level input.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : 8N1 UART receiver with mid-bit sampling and valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD),
  parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_bit_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_half_bit = c_cnt_w'(CLKS_PER_BIT / 2);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_BITS - 1);

  logic rxs;

  rx_state_e              state_q,     state_d;
  logic [c_cnt_w-1:0]     cnt_q,       cnt_d;
  logic [c_bit_w-1:0]     bit_q,       bit_d;
  logic [DATA_BITS-1:0]   shift_q,     shift_d;
  logic [DATA_BITS-1:0]   rx_data_q,   rx_data_d;
  logic                   rx_valid_q,  rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q,   overrun_d;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rx),
    .q     (rxs)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          // The cycle that sees the start edge is clock 0 of the start bit.
          state_d = START;
          cnt_d   = c_cnt_one;
        end
      end

      START: begin
        if (cnt_q == c_half_bit) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == c_last_cnt) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          if (bit_q == c_last_bit) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == c_last_cnt) begin
          cnt_d = '0;
          if (rxs) begin
            // Back to IDLE at mid-stop so a following start bit is not missed.
            state_d = IDLE;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BREAK: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Brief    : Directed, table-driven bench for uart_rx_core at 16 clocks/bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  localparam int CPB     = 16;
  localparam int LATENCY = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  // 153600 / 9600 rounds to 16 clocks per bit.
  uart_rx_core #(
    .CLK_FREQ  (153_600),
    .BAUD      (9600),
    .DATA_BITS (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   valid_rises = 0;
  int   valid_cycles = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  int   rise_cyc = 0;
  int   ovr_cyc = 0;
  int   start_cyc = 0;
  logic prev_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) valid_cycles++;
    if (rx_valid && !prev_valid) begin
      valid_rises++;
      rise_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int nclk);
    uart_rx = v;
    repeat (nclk) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    start_cyc = cyc;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    drive(stop_bit, CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle_bits;
    int         exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  int b_rise, b_cyc, b_ferr, b_ovr;

  task automatic snap();
    b_rise = valid_rises;
    b_cyc  = valid_cycles;
    b_ferr = ferr_cnt;
    b_ovr  = ovr_cnt;
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 2, 1, 8'h55, 0};
    vecs[1] = '{8'h7C, 1'b1, 4, 1, 8'h7C, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 1, 8'h00, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 1, 8'hFF, 0};
    vecs[4] = '{8'hC3, 1'b0, 2, 0, 8'hFF, 1};
    vecs[5] = '{8'h81, 1'b1, 3, 1, 8'h81, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      snap();
      drive(1'b1, vecs[i].idle_bits * CPB);
      send_frame(vecs[i].data, vecs[i].stop);
      drive(1'b1, 2 * CPB);
      chk($sformatf("vec%0d_valid_rises", i), valid_rises - b_rise, vecs[i].exp_valid);
      chk($sformatf("vec%0d_valid_cycles", i), valid_cycles - b_cyc, vecs[i].exp_valid);
      chk($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      chk($sformatf("vec%0d_frame_err", i), ferr_cnt - b_ferr, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_overrun", i), ovr_cnt - b_ovr, 0);
      if (i == 0) chk("vec0_latency", rise_cyc - start_cyc, LATENCY);
    end

    // Short glitch aborts at the half-bit check.
    snap();
    drive(1'b1, CPB);
    drive(1'b0, 3);
    chk("glitch_busy_high", int'(busy), 1);
    drive(1'b1, 2 * CPB);
    chk("glitch_busy_low", int'(busy), 0);
    chk("glitch_no_valid", valid_rises - b_rise, 0);
    chk("glitch_no_ferr", ferr_cnt - b_ferr, 0);

    // Framing error followed by a held-low break, then recovery.
    snap();
    send_frame(8'hA3, 1'b0);
    drive(1'b0, 3 * CPB);
    chk("break_ferr_once", ferr_cnt - b_ferr, 1);
    chk("break_busy", int'(busy), 1);
    drive(1'b1, 2 * CPB);
    chk("break_ferr_after_high", ferr_cnt - b_ferr, 1);
    chk("break_no_valid", valid_rises - b_rise, 0);
    send_frame(8'h0F, 1'b1);
    drive(1'b1, 2 * CPB);
    chk("recover_valid", valid_rises - b_rise, 1);
    chk("recover_data", int'(rx_data), 8'h0F);

    // Back-to-back frames while the consumer stalls.
    rx_ready = 1'b0;
    snap();
    drive(1'b1, 2 * CPB);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drive(1'b1, CPB);
    chk("ovr_valid_rises", valid_rises - b_rise, 1);
    chk("ovr_rx_valid", int'(rx_valid), 1);
    chk("ovr_rx_data", int'(rx_data), 8'h11);
    chk("ovr_pulses", ovr_cnt - b_ovr, 1);
    chk("ovr_timing", ovr_cyc - start_cyc, LATENCY);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid_before_accept", int'(rx_valid), 1);
    @(posedge clk);
    #1;
    chk("ovr_valid_after_accept", int'(rx_valid), 0);
    chk("ovr_data_kept", int'(rx_data), 8'h11);

    // Asynchronous reset in the middle of data bit 4.
    rx_ready = 1'b0;
    drive(1'b1, 2 * CPB);
    send_frame(8'h33, 1'b1);
    drive(1'b1, CPB);
    chk("pre_rst_valid", int'(rx_valid), 1);
    chk("pre_rst_data", int'(rx_data), 8'h33);
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b1, CPB);
    drive(1'b0, CPB / 2);
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(rx_valid), 0);
    chk("async_rst_data", int'(rx_data), 0);
    chk("async_rst_busy", int'(busy), 0);
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_ready = 1'b1;
    snap();
    drive(1'b1, 2 * CPB);
    send_frame(8'h5A, 1'b1);
    drive(1'b1, 2 * CPB);
    chk("post_rst_valid", valid_rises - b_rise, 1);
    chk("post_rst_data", int'(rx_data), 8'h5A);
    chk("post_rst_ferr", ferr_cnt - b_ferr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Receive-side serial front end that sits directly upstream of the byte-consuming logic in top, for example a loopback to the transmitter or a status register.
- Synchronises the asynchronous uart_rx pin.
- Detects and qualifies the start bit, then samples 8N1 frames at mid-bit.
- Presents each received byte on a valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate in bits per second
CLKS_PER_BIT, CLK_FREQ/BAUD rounded to nearest (10417), clocks per bit period; must be >= 4
DATA_BITS, 8, data bits per frame, LSB first

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  serial line; idles high; asynchronous to clk
rx_data  out  DATA_BITS  received byte; stable while rx_valid=1
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  consumer accepts when rx_valid && rx_ready at a rising edge
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: new frame completed while rx_valid=1 and rx_ready=0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, synchroniser flops=1 (idle level).
- uart_rx passes through a 2-flop synchroniser. Call the synchronised signal rxs; all decisions use rxs.
- One bit counter and one clock counter. The clock counter counts 0..CLKS_PER_BIT-1 and reloads at each sample point.
- IDLE: on rxs=0, go to START and clear the clock counter.
- START: at count CLKS_PER_BIT/2 (integer), sample rxs.
  - rxs=1: false start; return to IDLE with no outputs.
  - rxs=0: go to DATA, bit index 0, restart the clock counter.
- DATA: every CLKS_PER_BIT clocks, sample rxs into shift[bit index], LSB first. After bit DATA_BITS-1, go to STOP.
- STOP: after CLKS_PER_BIT clocks, sample rxs. The frame completes at that sample.
  - rxs=1:
    - If rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data with shift and set rx_valid=1 next cycle.
    - If rx_valid=1 and rx_ready=0: pulse overrun; rx_data keeps the old byte; the new byte is dropped.
    - Go to IDLE.
  - rxs=0: pulse frame_err; discard the byte; go to BREAK.
- BREAK: wait for rxs=1, then go to IDLE. A held-low line (break condition) never produces repeated frame_err.
- Handshake: rx_valid falls on the clock after rx_valid && rx_ready. A simultaneous accept and new load leaves rx_valid=1 with the new data.
- Latency: rx_valid rises one clock after the stop mid-sample. That is 2 synchroniser clocks + (CLKS_PER_BIT/2) + (DATA_BITS+1)*CLKS_PER_BIT + 1 clocks after the pin's falling start edge.
- Returning to IDLE at stop mid-sample allows back-to-back frames with no idle bits between them.
- Asynchronous reset mid-frame: all state returns to IDLE immediately and any partial byte is lost. After rst_n deasserts, a line already low is treated as a new start edge.

Decomposition:
- Shared package uart_pkg:
  - rx state enum {IDLE, START, DATA, STOP, BREAK}
  - function computing CLKS_PER_BIT from CLK_FREQ/BAUD with rounding
  - DATA_BITS default constant
  - shared with the future tx block
- One sub-module: uart_sync2, a 2-flop synchroniser with reset value 1. It is also reused for read_enable in top.

Test Plan:
- Frame line 1,0,1,0,1,0,1,0 (LSB first) after 2 idle bits, rx_ready=1 -> one rx_valid pulse with rx_data=0x55; frame_err=0; rx_valid rises 9.5 bit times + 3 clocks after the start edge.
- Frame 0,0,1,1,1,1,1,0 after 4 idle bits, rx_ready=1 -> rx_data=0x7C, single valid cycle.
- 3-µs low glitch on idle line -> START aborts at half-bit; no rx_valid and no frame_err; busy returns to 0.
- Frame 0xA3 with stop bit forced 0, then line held low 3 bit times -> exactly one frame_err pulse, no rx_valid; after line returns high, frame 0x0F is received correctly.
- rx_ready=0, frames 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun pulses once at the second stop mid-sample; raising rx_ready clears rx_valid next clock.
- rst_n asserted mid-data-bit 4 -> all outputs 0 immediately; next full frame 0x5A is received correctly.
